// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/DIV sequencer that owns the HI/LO registers for the E stage.
// Optional abort path compiled in with MULDIV_CANCEL_EN (adds the CANCEL port).

// state | meaning
// IDLE  | no op in flight; accepts START (arith op, MTHI/MTLO, no-op)
// RUN   | result held in p_hi/p_lo, counting down to commit
module muldiv_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        START,
    input  logic [2:0]  OP,
    input  logic [31:0] A,
    input  logic [31:0] B,
`ifdef MULDIV_CANCEL_EN
    input  logic        CANCEL,
`endif
    output logic        BUSY,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        busy_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [31:0] p_hi;
    logic [31:0] p_lo;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               div_zero;
    logic               div_ovf;
    logic        [31:0] safe_b;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;
    logic        [31:0] res_hi;
    logic        [31:0] res_lo;

    assign prod_s = $signed(A) * $signed(B);
    assign prod_u = {32'd0, A} * {32'd0, B};

    // The divider never sees 0 or the INT_MIN / -1 pair; both are patched below.
    assign div_zero = (B == 32'd0);
    assign div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF) && !OP[0];
    assign safe_b   = (div_zero || div_ovf) ? 32'd1 : B;
    assign quot_s   = $signed(A) / $signed(safe_b);
    assign rem_s    = $signed(A) % $signed(safe_b);
    assign quot_u   = A / safe_b;
    assign rem_u    = A % safe_b;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (OP[1:0])
            2'b00: {res_hi, res_lo} = prod_s;
            2'b01: {res_hi, res_lo} = prod_u;
            default: begin
                if (div_zero) begin
                    res_hi = A;
                    res_lo = 32'hFFFF_FFFF;
                end else if (div_ovf) begin
                    res_hi = 32'd0;
                    res_lo = 32'h8000_0000;
                end else if (!OP[0]) begin
                    res_hi = rem_s;
                    res_lo = quot_s;
                end else begin
                    res_hi = rem_u;
                    res_lo = quot_u;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            busy_r <= 1'b0;
            hi_r   <= 32'd0;
            lo_r   <= 32'd0;
            p_hi   <= 32'd0;
            p_lo   <= 32'd0;
        end
`ifdef MULDIV_CANCEL_EN
        else if (CANCEL) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            busy_r <= 1'b0;
        end
`endif
        else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        if (!OP[2]) begin
                            p_hi   <= res_hi;
                            p_lo   <= res_lo;
                            cnt    <= OP[1] ? DIV_LOAD : MULT_LOAD;
                            state  <= RUN;
                            busy_r <= 1'b1;
                        end else if (OP == 3'b100) begin
                            hi_r <= A;
                        end else if (OP == 3'b101) begin
                            lo_r <= A;
                        end
                    end
                end
                RUN: begin
                    if (cnt == 4'd0) begin
                        hi_r   <= p_hi;
                        lo_r   <= p_lo;
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY = busy_r;
    assign HI   = hi_r;
    assign LO   = lo_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: default-parameter DUT plus an N=1 / N=15 instance.
// Cancel scenarios are compiled only when MULDIV_CANCEL_EN is defined.
module tb_muldiv_ctrl;

    logic        clk;
    logic        reset;
    logic        START;
    logic [2:0]  OP;
    logic [31:0] A;
    logic [31:0] B;
    logic        CANCEL;
    logic        BUSY, BUSY1;
    logic [31:0] HI, LO, HI1, LO1;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b110;

    muldiv_ctrl dut (
        .clk(clk), .reset(reset), .START(START), .OP(OP), .A(A), .B(B),
`ifdef MULDIV_CANCEL_EN
        .CANCEL(CANCEL),
`endif
        .BUSY(BUSY), .HI(HI), .LO(LO)
    );

    muldiv_ctrl #(.MULT_CYCLES(1), .DIV_CYCLES(15)) dut1 (
        .clk(clk), .reset(reset), .START(START), .OP(OP), .A(A), .B(B),
`ifdef MULDIV_CANCEL_EN
        .CANCEL(CANCEL),
`endif
        .BUSY(BUSY1), .HI(HI1), .LO(LO1)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge after BUSY has fallen.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int busy_cnt);
        START = 1'b1; OP = op; A = a; B = b;
        @(negedge clk);
        START = 1'b0; OP = OP_NOP;
        busy_cnt = 0;
        while (BUSY && busy_cnt < 40) begin
            busy_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
        n_checks++; if (HI !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", HI); end
        n_checks++; if (LO !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", LO); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int n;
        do_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, n);
        n_checks++; if (n !== 5) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d expected 5", n); end
        n_checks++; if (HI !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected ffffffff", HI); end
        n_checks++; if (LO !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL mult_lo: got %h expected fffffffa", LO); end
    endtask

    task automatic test_multu();
        int n;
        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        n_checks++; if (n !== 5) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d expected 5", n); end
        n_checks++; if (HI !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi: got %h expected fffffffe", HI); end
        n_checks++; if (LO !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo: got %h expected 00000001", LO); end
    endtask

    task automatic test_div();
        int n;
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, n);
        n_checks++; if (n !== 10) begin n_fail++; $display("FAIL div_busy_cycles: got %0d expected 10", n); end
        n_checks++; if (LO !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_lo: got %h expected fffffffd", LO); end
        n_checks++; if (HI !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_hi: got %h expected ffffffff", HI); end

        do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, n);
        n_checks++; if (LO !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_negb_lo: got %h expected fffffffd", LO); end
        n_checks++; if (HI !== 32'd1) begin n_fail++; $display("FAIL div_negb_hi: got %h expected 00000001", HI); end

        do_op(OP_DIVU, 32'd5, 32'd0, n);
        n_checks++; if (n !== 10) begin n_fail++; $display("FAIL divz_busy_cycles: got %0d expected 10", n); end
        n_checks++; if (HI !== 32'd5) begin n_fail++; $display("FAIL divz_hi: got %h expected 00000005", HI); end
        n_checks++; if (LO !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divz_lo: got %h expected ffffffff", LO); end

        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
        n_checks++; if (LO !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo: got %h expected 80000000", LO); end
        n_checks++; if (HI !== 32'd0) begin n_fail++; $display("FAIL div_ovf_hi: got %h expected 00000000", HI); end

        do_op(OP_DIVU, 32'd100, 32'd7, n);
        n_checks++; if (LO !== 32'd14) begin n_fail++; $display("FAIL divu_lo: got %h expected 0000000e", LO); end
        n_checks++; if (HI !== 32'd2) begin n_fail++; $display("FAIL divu_hi: got %h expected 00000002", HI); end
    endtask

    task automatic test_mthi_mtlo();
        START = 1'b1; OP = OP_MTHI; A = 32'h1234_5678; B = 32'd0;
        @(negedge clk);
        START = 1'b0; OP = OP_NOP;
        n_checks++; if (HI !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi_hi: got %h expected 12345678", HI); end
        n_checks++; if (LO !== 32'd14) begin n_fail++; $display("FAIL mthi_lo_kept: got %h expected 0000000e", LO); end
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL mthi_busy: got %b expected 0", BUSY); end

        START = 1'b1; OP = OP_MTLO; A = 32'hCAFE_F00D;
        @(negedge clk);
        START = 1'b0; OP = OP_NOP;
        n_checks++; if (LO !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL mtlo_lo: got %h expected cafef00d", LO); end
        n_checks++; if (HI !== 32'h1234_5678) begin n_fail++; $display("FAIL mtlo_hi_kept: got %h expected 12345678", HI); end

        START = 1'b1; OP = OP_NOP; A = 32'hDEAD_BEEF; B = 32'd3;
        @(negedge clk);
        START = 1'b0;
        @(negedge clk);
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL nop_busy: got %b expected 0", BUSY); end
        n_checks++; if (HI !== 32'h1234_5678) begin n_fail++; $display("FAIL nop_hi: got %h expected 12345678", HI); end
        n_checks++; if (LO !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL nop_lo: got %h expected cafef00d", LO); end
    endtask

    task automatic test_start_during_run();
        int n;
        START = 1'b1; OP = OP_DIV; A = 32'd20; B = 32'd6;
        @(negedge clk);
        START = 1'b0; OP = OP_NOP;
        n = 0;
        while (BUSY && n < 40) begin
            if (n == 2) begin
                START = 1'b1; OP = OP_MULT; A = 32'd5; B = 32'd5;
            end else begin
                START = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        START = 1'b0; OP = OP_NOP;
        n_checks++; if (n !== 10) begin n_fail++; $display("FAIL ignore_busy_cycles: got %0d expected 10", n); end
        n_checks++; if (HI !== 32'd2) begin n_fail++; $display("FAIL ignore_hi: got %h expected 00000002", HI); end
        n_checks++; if (LO !== 32'd3) begin n_fail++; $display("FAIL ignore_lo: got %h expected 00000003", LO); end
        @(negedge clk);
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL ignore_no_restart: got %b expected 0", BUSY); end
    endtask

    task automatic test_back_to_back();
        int n;
        do_op(OP_MULT, 32'd3, 32'd4, n);
        n_checks++; if (LO !== 32'd12) begin n_fail++; $display("FAIL b2b_first_lo: got %h expected 0000000c", LO); end
        do_op(OP_MULTU, 32'd6, 32'd7, n);
        n_checks++; if (n !== 5) begin n_fail++; $display("FAIL b2b_second_busy: got %0d expected 5", n); end
        n_checks++; if (LO !== 32'd42) begin n_fail++; $display("FAIL b2b_second_lo: got %h expected 0000002a", LO); end
        n_checks++; if (HI !== 32'd0) begin n_fail++; $display("FAIL b2b_second_hi: got %h expected 00000000", HI); end
    endtask

    task automatic test_cycle_bounds();
        int n;
        START = 1'b1; OP = OP_MULT; A = 32'd2; B = 32'd3;
        @(negedge clk);
        START = 1'b0; OP = OP_NOP;
        n_checks++; if (BUSY1 !== 1'b1) begin n_fail++; $display("FAIL n1_busy_high: got %b expected 1", BUSY1); end
        @(negedge clk);
        n_checks++; if (BUSY1 !== 1'b0) begin n_fail++; $display("FAIL n1_busy_low: got %b expected 0", BUSY1); end
        n_checks++; if (LO1 !== 32'd6) begin n_fail++; $display("FAIL n1_lo: got %h expected 00000006", LO1); end
        n_checks++; if (HI1 !== 32'd0) begin n_fail++; $display("FAIL n1_hi: got %h expected 00000000", HI1); end

        START = 1'b1; OP = OP_DIVU; A = 32'd9; B = 32'd3;
        @(negedge clk);
        START = 1'b0; OP = OP_NOP;
        n = 0;
        while (BUSY1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        n_checks++; if (n !== 15) begin n_fail++; $display("FAIL n15_busy_cycles: got %0d expected 15", n); end
        n_checks++; if (LO1 !== 32'd3) begin n_fail++; $display("FAIL n15_lo: got %h expected 00000003", LO1); end
        n = 0;
        while (BUSY && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_during_run();
        START = 1'b1; OP = OP_DIV; A = 32'd100; B = 32'd7;
        @(negedge clk);
        START = 1'b0; OP = OP_NOP;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL rrun_busy: got %b expected 0", BUSY); end
        n_checks++; if (HI !== 32'd0) begin n_fail++; $display("FAIL rrun_hi: got %h expected 00000000", HI); end
        n_checks++; if (LO !== 32'd0) begin n_fail++; $display("FAIL rrun_lo: got %h expected 00000000", LO); end
        reset = 1'b0;
        repeat (15) @(negedge clk);
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL rrun_late_busy: got %b expected 0", BUSY); end
        n_checks++; if (LO !== 32'd0) begin n_fail++; $display("FAIL rrun_late_lo: got %h expected 00000000", LO); end
        n_checks++; if (HI !== 32'd0) begin n_fail++; $display("FAIL rrun_late_hi: got %h expected 00000000", HI); end
    endtask

`ifdef MULDIV_CANCEL_EN
    task automatic test_cancel();
        START = 1'b1; OP = OP_MTHI; A = 32'h1111_1111;
        @(negedge clk);
        OP = OP_MTLO; A = 32'h2222_2222;
        @(negedge clk);
        OP = OP_MULT; A = 32'd2; B = 32'd3;
        @(negedge clk);
        START = 1'b0; OP = OP_NOP;
        repeat (4) @(negedge clk);
        CANCEL = 1'b1;
        @(negedge clk);
        CANCEL = 1'b0;
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL cancel_busy: got %b expected 0", BUSY); end
        n_checks++; if (HI !== 32'h1111_1111) begin n_fail++; $display("FAIL cancel_hi: got %h expected 11111111", HI); end
        n_checks++; if (LO !== 32'h2222_2222) begin n_fail++; $display("FAIL cancel_lo: got %h expected 22222222", LO); end
        repeat (8) @(negedge clk);
        n_checks++; if (LO !== 32'h2222_2222) begin n_fail++; $display("FAIL cancel_late_lo: got %h expected 22222222", LO); end

        START = 1'b1; CANCEL = 1'b1; OP = OP_MTHI; A = 32'h9999_9999;
        @(negedge clk);
        START = 1'b0; CANCEL = 1'b0; OP = OP_NOP;
        n_checks++; if (HI !== 32'h1111_1111) begin n_fail++; $display("FAIL cancel_mthi_hi: got %h expected 11111111", HI); end
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL cancel_start_busy: got %b expected 0", BUSY); end
    endtask
`endif

    initial begin
        clk = 1'b0; reset = 1'b1; START = 1'b0; OP = OP_NOP; A = 32'd0; B = 32'd0; CANCEL = 1'b0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_mthi_mtlo();
        test_start_during_run();
        test_back_to_back();
        test_cycle_bounds();
        test_reset_during_run();
`ifdef MULDIV_CANCEL_EN
        test_cancel();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
